// File: rtl/tri_pkg.sv
// Shared widths, packed-triangle layout and controller state encoding
// for the triangle dispatch controller.
package tri_pkg;

  localparam int X_W   = 12;
  localparam int Y_W   = 12;
  localparam int Z_W   = 21;
  localparam int C_W   = 24;
  localparam int VTX_W = X_W + Y_W + Z_W + C_W;
  localparam int TRI_W = 3 * VTX_W;

  localparam int C_OFF = 0;
  localparam int Z_OFF = C_OFF + C_W;
  localparam int Y_OFF = Z_OFF + Z_W;
  localparam int X_OFF = Y_OFF + Y_W;

  localparam int V1_OFF = 0;
  localparam int V2_OFF = VTX_W;
  localparam int V3_OFF = 2 * VTX_W;

  localparam int NUM_W = 21;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  function automatic logic st_busy(state_e s);
    return (s == ST_FETCH) || (s == ST_WAIT_MEM) ||
           (s == ST_ISSUE) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/tri_fifo.sv
// Shaded-triangle buffer: power-of-2 circular FIFO with occupancy count.
// Head word reads as zero while empty so the output is clean after reset.
module tri_fifo #(
  parameter int WIDTH = 207,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   srst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [PW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = o_empty ? '0 : r_mem[r_rp];

  // Storage array: written at the tail, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  // Pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/tri_dispatch_ctrl.sv
// Frame dispatcher: fetches faces from SRAM, streams vertex indices to
// the shader and buffers shaded triangles for the rasterizer.
module tri_dispatch_ctrl
  import tri_pkg::*;
#(
  parameter int SRAM_LAT   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 20,
  parameter int VIDX_W     = 20
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_face,
  input  logic [NUM_W-1:0]  num_faces,
  output logic              face_rd,
  output logic [ADDR_W-1:0] face_addr,
  input  logic [VIDX_W-1:0] face_v1,
  input  logic [VIDX_W-1:0] face_v2,
  input  logic [VIDX_W-1:0] face_v3,
  output logic              shd_valid,
  output logic [VIDX_W-1:0] shd_vidx,
  input  logic              shd_done,
  input  logic [TRI_W-1:0]  shd_tri,
  output logic              ras_valid,
  output logic [TRI_W-1:0]  ras_tri,
  input  logic              ras_ready,
  output logic              busy,
  output logic              finish,
  output logic              err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OW    = CNT_W + 1;
  localparam logic [2:0] LAT_C = 3'(SRAM_LAT);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic [NUM_W-1:0]  r_num, w_num_nxt;
  logic [NUM_W-1:0]  r_issued, w_issued_nxt;
  logic [CNT_W-1:0]  r_inflight, w_inflight_nxt;
  logic [OW-1:0]     r_orphan, w_orst;
  logic [2:0]        r_lat, w_lat_nxt;
  logic [1:0]        r_beat, w_beat_nxt;
  logic [VIDX_W-1:0] r_v2, w_v2_nxt;
  logic [VIDX_W-1:0] r_v3, w_v3_nxt;
  logic              r_face_rd, w_face_rd_nxt;
  logic [ADDR_W-1:0] r_face_addr, w_face_addr_nxt;
  logic              r_shd_valid, w_shd_valid_nxt;
  logic [VIDX_W-1:0] r_shd_vidx, w_shd_vidx_nxt;
  logic              r_busy, r_finish, r_err;
  logic              w_inc;

  logic              w_orph_hit, w_push, w_bad;
  logic              w_credit;
  logic [CNT_W-1:0]  w_fcnt;
  logic              w_full, w_empty;
  logic [CNT_W:0]    w_used;

  assign face_rd   = r_face_rd;
  assign face_addr = r_face_addr;
  assign shd_valid = r_shd_valid;
  assign shd_vidx  = r_shd_vidx;
  assign busy      = r_busy;
  assign finish    = r_finish;
  assign err       = r_err;
  assign ras_valid = !w_empty;

  assign w_used   = {1'b0, r_inflight} + {1'b0, w_fcnt};
  assign w_credit = (w_used < (CNT_W+1)'(FIFO_DEPTH));

  // Results still owed by the shader from an abandoned frame are
  // swallowed first; the shader returns triangles in issue order.
  assign w_orph_hit = shd_done && (r_orphan != '0);
  assign w_push = shd_done && !w_orph_hit &&
                  (r_inflight != '0) && !w_full;
  assign w_bad  = shd_done && !w_orph_hit && (r_inflight == '0);
  assign w_orst = r_orphan + OW'(r_inflight);

  tri_fifo #(
    .WIDTH (TRI_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst_n  (srst_n),
    .i_push  (w_push),
    .i_data  (shd_tri),
    .i_pop   (ras_ready),
    .o_data  (ras_tri),
    .o_count (w_fcnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state and next-output decode for the dispatch sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_base_nxt      = r_base;
    w_num_nxt       = r_num;
    w_issued_nxt    = r_issued;
    w_lat_nxt       = r_lat;
    w_beat_nxt      = r_beat;
    w_v2_nxt        = r_v2;
    w_v3_nxt        = r_v3;
    w_face_rd_nxt   = 1'b0;
    w_face_addr_nxt = r_face_addr;
    w_shd_valid_nxt = 1'b0;
    w_shd_vidx_nxt  = r_shd_vidx;
    w_inc           = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_base_nxt   = base_face;
          w_num_nxt    = num_faces;
          w_issued_nxt = '0;
          w_state_nxt  = (num_faces != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (w_credit) begin
          w_face_rd_nxt   = 1'b1;
          w_face_addr_nxt = r_base + ADDR_W'(r_issued);
          w_lat_nxt       = '0;
          w_state_nxt     = ST_WAIT_MEM;
        end
      end
      ST_WAIT_MEM: begin
        if (r_lat == LAT_C) begin
          w_v2_nxt        = face_v2;
          w_v3_nxt        = face_v3;
          w_shd_valid_nxt = 1'b1;
          w_shd_vidx_nxt  = face_v1;
          w_beat_nxt      = 2'd0;
          w_inc           = 1'b1;
          w_issued_nxt    = r_issued + NUM_W'(1);
          w_state_nxt     = ST_ISSUE;
        end else begin
          w_lat_nxt = r_lat + 3'd1;
        end
      end
      ST_ISSUE: begin
        unique case (r_beat)
          2'd0: begin
            w_shd_valid_nxt = 1'b1;
            w_shd_vidx_nxt  = r_v2;
            w_beat_nxt      = 2'd1;
          end
          2'd1: begin
            w_shd_valid_nxt = 1'b1;
            w_shd_vidx_nxt  = r_v3;
            w_beat_nxt      = 2'd2;
          end
          default: begin
            w_beat_nxt  = 2'd0;
            w_state_nxt = (r_issued == r_num) ? ST_DRAIN : ST_FETCH;
          end
        endcase
      end
      ST_DRAIN: begin
        if ((r_inflight == '0) && w_empty) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_inflight_nxt = r_inflight + CNT_W'(w_inc) - CNT_W'(w_push);
  end

  // State and registered outputs; reset remembers owed shader results.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_num       <= '0;
      r_issued    <= '0;
      r_inflight  <= '0;
      r_orphan    <= (shd_done && (w_orst != '0)) ? w_orst - OW'(1) : w_orst;
      r_lat       <= '0;
      r_beat      <= '0;
      r_v2        <= '0;
      r_v3        <= '0;
      r_face_rd   <= 1'b0;
      r_face_addr <= '0;
      r_shd_valid <= 1'b0;
      r_shd_vidx  <= '0;
      r_busy      <= 1'b0;
      r_finish    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_num       <= w_num_nxt;
      r_issued    <= w_issued_nxt;
      r_inflight  <= w_inflight_nxt;
      r_orphan    <= w_orph_hit ? r_orphan - OW'(1) : r_orphan;
      r_lat       <= w_lat_nxt;
      r_beat      <= w_beat_nxt;
      r_v2        <= w_v2_nxt;
      r_v3        <= w_v3_nxt;
      r_face_rd   <= w_face_rd_nxt;
      r_face_addr <= w_face_addr_nxt;
      r_shd_valid <= w_shd_valid_nxt;
      r_shd_vidx  <= w_shd_vidx_nxt;
      r_busy      <= st_busy(w_state_nxt);
      r_finish    <= (w_state_nxt == ST_DONE);
      r_err       <= r_err | w_bad;
    end
  end

endmodule

// File: tb/tb_tri_dispatch_ctrl.sv
// Scoreboard bench for tri_dispatch_ctrl with SRAM and shader models.
// Expected addresses and triangles are queued when a frame is started.
module tb_tri_dispatch_ctrl;
  import tri_pkg::*;

  localparam int LAT = 2;
  localparam int DEPTH = 4;
  localparam int AW = 20;
  localparam int VW = 20;

  logic              clk = 1'b0;
  logic              srst_n;
  logic              start;
  logic [AW-1:0]     base_face;
  logic [NUM_W-1:0]  num_faces;
  logic              face_rd;
  logic [AW-1:0]     face_addr;
  logic [VW-1:0]     face_v1, face_v2, face_v3;
  logic              shd_valid;
  logic [VW-1:0]     shd_vidx;
  logic              shd_done = 1'b0;
  logic [TRI_W-1:0]  shd_tri = '0;
  logic              ras_valid;
  logic [TRI_W-1:0]  ras_tri;
  logic              ras_ready;
  logic              busy, finish, err;

  always #5 clk = ~clk;

  tri_dispatch_ctrl #(
    .SRAM_LAT   (LAT),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .VIDX_W     (VW)
  ) dut (
    .clk       (clk),
    .srst_n    (srst_n),
    .start     (start),
    .base_face (base_face),
    .num_faces (num_faces),
    .face_rd   (face_rd),
    .face_addr (face_addr),
    .face_v1   (face_v1),
    .face_v2   (face_v2),
    .face_v3   (face_v3),
    .shd_valid (shd_valid),
    .shd_vidx  (shd_vidx),
    .shd_done  (shd_done),
    .shd_tri   (shd_tri),
    .ras_valid (ras_valid),
    .ras_tri   (ras_tri),
    .ras_ready (ras_ready),
    .busy      (busy),
    .finish    (finish),
    .err       (err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int beat_cnt = 0;
  int ras_cnt = 0;

  logic [AW-1:0]    addr_q [$];
  logic [TRI_W-1:0] tri_q [$];
  int               due_q [$];
  logic [TRI_W-1:0] sh_q [$];
  logic [VW-1:0]    vb [3];
  int               nb = 0;
  logic [AW-1:0]    p_addr [LAT];

  task automatic check_eq(input string tag, input logic [255:0] got,
                          input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [VW-1:0] vd(input logic [AW-1:0] a, input int k);
    return VW'(a * 5 + k + 7);
  endfunction

  function automatic logic [VTX_W-1:0] vtx(input logic [VW-1:0] v);
    logic [VTX_W-1:0] r;
    r = '0;
    r[X_OFF +: X_W] = X_W'(v);
    r[Y_OFF +: Y_W] = Y_W'(v >> 8);
    r[Z_OFF +: Z_W] = Z_W'(v * 3);
    r[C_OFF +: C_W] = C_W'(v ^ 20'h5A5A5);
    return r;
  endfunction

  function automatic logic [TRI_W-1:0] tri_of(input logic [VW-1:0] a,
                                              input logic [VW-1:0] b,
                                              input logic [VW-1:0] c);
    logic [TRI_W-1:0] t;
    t = '0;
    t[V1_OFF +: VTX_W] = vtx(a);
    t[V2_OFF +: VTX_W] = vtx(b);
    t[V3_OFF +: VTX_W] = vtx(c);
    return t;
  endfunction

  // SRAM model: read data appears LAT cycles after the strobe is sampled.
  always @(posedge clk) begin
    p_addr[0] <= face_addr;
    for (int i = 1; i < LAT; i++) p_addr[i] <= p_addr[i-1];
    cyc <= cyc + 1;
  end
  assign face_v1 = vd(p_addr[LAT-1], 0);
  assign face_v2 = vd(p_addr[LAT-1], 1);
  assign face_v3 = vd(p_addr[LAT-1], 2);

  // Shader model and output monitors, all sampled on the falling edge.
  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      shd_done = 1'b1;
      shd_tri = sh_q[0];
      void'(due_q.pop_front());
      void'(sh_q.pop_front());
    end else begin
      shd_done = 1'b0;
    end
    if (!srst_n) nb = 0;
    else if (shd_valid) begin
      vb[nb] = shd_vidx;
      nb++;
      beat_cnt++;
      if (nb == 3) begin
        due_q.push_back(cyc + 4);
        sh_q.push_back(tri_of(vb[0], vb[1], vb[2]));
        nb = 0;
      end
    end
    if (face_rd) begin
      rd_cnt++;
      check_eq("rd_expected", addr_q.size() > 0, 1);
      if (addr_q.size() > 0) check_eq("face_addr", face_addr, addr_q.pop_front());
    end
    if (ras_valid) begin
      check_eq("ras_expected", tri_q.size() > 0, 1);
      if (tri_q.size() > 0) begin
        check_eq("ras_tri", ras_tri, tri_q[0]);
        if (ras_ready) begin
          void'(tri_q.pop_front());
          ras_cnt++;
        end
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] b, input int n,
                             input bit expect_it);
    if (expect_it) begin
      for (int i = 0; i < n; i++) begin
        logic [AW-1:0] a;
        a = AW'(b + i);
        addr_q.push_back(a);
        tri_q.push_back(tri_of(vd(a, 0), vd(a, 1), vd(a, 2)));
      end
    end
    @(posedge clk);
    #1;
    base_face = b;
    num_faces = NUM_W'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_finish(input string tag, input int maxc);
    int k;
    k = 0;
    while (!finish && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, finish, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"},
             {face_rd, shd_valid, ras_valid, busy, finish, err}, 6'd0);
    check_eq({tag, "_addr"}, face_addr, 0);
    check_eq({tag, "_vidx"}, shd_vidx, 0);
    check_eq({tag, "_tri"}, ras_tri, 0);
  endtask

  initial begin
    int r0, b0, c0, k;
    srst_n = 1'b0;
    start = 1'b0;
    base_face = '0;
    num_faces = '0;
    ras_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk);
    #1 srst_n = 1'b1;

    // Empty frame goes straight to DONE.
    r0 = rd_cnt;
    pulse_start(20'h40, 0, 1'b1);
    wait_finish("n0_finish", 2);
    check_eq("n0_busy", busy, 0);
    repeat (3) @(negedge clk);
    check_eq("n0_no_rd", rd_cnt - r0, 0);

    // Three-face frame; a second start while busy is ignored.
    r0 = rd_cnt; b0 = beat_cnt; c0 = ras_cnt;
    pulse_start(20'h10, 3, 1'b1);
    check_eq("restart_fin_drop", finish, 0);
    check_eq("restart_busy", busy, 1);
    repeat (5) @(posedge clk);
    pulse_start(20'h999, 5, 1'b0);
    wait_finish("f3_finish", 200);
    check_eq("f3_rd", rd_cnt - r0, 3);
    check_eq("f3_beats", beat_cnt - b0, 9);
    check_eq("f3_ras", ras_cnt - c0, 3);
    check_eq("f3_left", tri_q.size(), 0);

    // Address wraps modulo 2^ADDR_W.
    r0 = rd_cnt; c0 = ras_cnt;
    pulse_start(20'hFFFFE, 3, 1'b1);
    wait_finish("wrap_finish", 200);
    check_eq("wrap_rd", rd_cnt - r0, 3);
    check_eq("wrap_ras", ras_cnt - c0, 3);

    // Back-pressure: only FIFO_DEPTH faces fetched until rasterizer drains.
    r0 = rd_cnt; c0 = ras_cnt;
    @(posedge clk);
    #1 ras_ready = 1'b0;
    pulse_start(20'h100, 8, 1'b1);
    repeat (60) @(negedge clk);
    check_eq("bp_rd_stall", rd_cnt - r0, DEPTH);
    check_eq("bp_busy", busy, 1);
    check_eq("bp_ras_valid", ras_valid, 1);
    check_eq("bp_ras_none", ras_cnt - c0, 0);
    @(posedge clk);
    #1 ras_ready = 1'b1;
    wait_finish("bp_finish", 400);
    check_eq("bp_rd", rd_cnt - r0, 8);
    check_eq("bp_ras", ras_cnt - c0, 8);
    check_eq("bp_left", tri_q.size(), 0);

    // Reset mid-frame with a shader result still outstanding.
    b0 = beat_cnt;
    pulse_start(20'h200, 4, 1'b1);
    k = 0;
    while (beat_cnt - b0 < 3 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("mid_v3_seen", beat_cnt - b0, 3);
    srst_n = 1'b0;
    addr_q.delete();
    tri_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk);
    #1 srst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("orphan_delivered", due_q.size(), 0);
    check_eq("orphan_no_err", err, 0);
    check_eq("orphan_no_ras", ras_valid, 0);

    // Unsolicited shader result while idle is a sticky error.
    @(posedge clk);
    #1;
    due_q.push_back(cyc + 2);
    sh_q.push_back('1);
    repeat (5) @(negedge clk);
    check_eq("idle_done_err", err, 1);
    check_eq("idle_done_no_ras", ras_valid, 0);
    repeat (3) @(negedge clk);
    check_eq("err_sticky", err, 1);
    @(posedge clk);
    #1 srst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("err_cleared", err, 0);
    @(posedge clk);
    #1 srst_n = 1'b1;

    // Normal frame after recovery.
    r0 = rd_cnt; c0 = ras_cnt;
    pulse_start(20'h30, 2, 1'b1);
    wait_finish("post_finish", 200);
    check_eq("post_rd", rd_cnt - r0, 2);
    check_eq("post_ras", ras_cnt - c0, 2);
    check_eq("post_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tri_dispatch_ctrl.md
TRI_DISPATCH_CTRL -- requirements
Module: tri_dispatch_ctrl

Interface
REQ-001 Parameter SRAM_LAT, default 2, cycles from face_rd sampled by SRAM to face_v1..3 valid; legal 1..7.
REQ-002 Parameter FIFO_DEPTH, default 4, shaded-triangle buffer entries; power of 2, >=2.
REQ-003 Parameter ADDR_W, default 20, face address width.
REQ-004 Parameter VIDX_W, default 20, vertex index width.
REQ-005 clk  in  1  clock, rising edge; srst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle frame start pulse; base_face  in  ADDR_W  first face address; num_faces  in  21  faces in frame.
REQ-007 face_rd  out  1  SRAM read strobe; face_addr  out  ADDR_W  SRAM face address; face_v1/face_v2/face_v3  in  VIDX_W  SRAM face data.
REQ-008 shd_valid  out  1  vertex index valid to shader; shd_vidx  out  VIDX_W  vertex index.
REQ-009 shd_done  in  1  one-cycle pulse, shaded triangle on shd_tri; shd_tri  in  TRI_W (207)  three packed vertices {x12,y12,depth21,color24}, v1 in LSBs.
REQ-010 ras_valid  out  1  triangle available; ras_tri  out  TRI_W  triangle to rasterizer; ras_ready  in  1  rasterizer accepts.
REQ-011 busy  out  1  frame in progress; finish  out  1  frame complete; err  out  1  sticky protocol error.

Function
REQ-012 States: IDLE, FETCH, WAIT_MEM, ISSUE, DRAIN, DONE; all outputs registered.
REQ-013 IDLE: start latches base_face/num_faces, clears counters, goes FETCH (num_faces>0) or DONE (num_faces==0).
REQ-014 FETCH: only when credits available (inflight + fifo_count < FIFO_DEPTH); drive face_rd=1 for one cycle, face_addr = base + issued (mod 2^ADDR_W), go WAIT_MEM; otherwise stall with face_rd=0.
REQ-015 WAIT_MEM: count SRAM_LAT cycles, then sample face_v1..3 into holding register, go ISSUE.
REQ-016 ISSUE: shd_valid=1 on three consecutive cycles carrying v1, v2, v3; inflight and issued increment by 1 on the v1 cycle.
REQ-017 After v3: issued==num_faces -> DRAIN, else FETCH.
REQ-018 shd_done with inflight>0: push shd_tri into FIFO, inflight decrements; same-cycle increment and decrement net to zero change.
REQ-019 shd_done with inflight==0: no push, err set until reset.
REQ-020 ras_valid = FIFO not empty; pop on ras_valid & ras_ready; ras_tri stable while ras_valid & !ras_ready; same-cycle push and pop allowed, count unchanged.
REQ-021 Credit rule guarantees FIFO never overflows; push while full is impossible by construction.
REQ-022 DRAIN: inflight==0 and FIFO empty -> DONE.
REQ-023 DONE: finish=1 held; start returns via REQ-013 behaviour (restart); finish drops the cycle after start.
REQ-024 busy=1 in FETCH/WAIT_MEM/ISSUE/DRAIN; start while busy ignored.
REQ-025 Every face base..base+num_faces-1 delivered exactly once, in address order, including the last.

Reset
REQ-026 srst_n low: state IDLE, counters 0, FIFO empty, face_rd/shd_valid/ras_valid/busy/finish/err 0, face_addr/shd_vidx/ras_tri 0.
REQ-027 Reset mid-frame abandons frame; shader results arriving after reset are discarded without err.

Structure
REQ-028 Package tri_pkg holds field widths, TRI_W, packed-triangle field offsets, state encoding.
REQ-029 FIFO implemented as sub-module tri_fifo (parametrised WIDTH/DEPTH, count, full/empty).

Verification
REQ-030 base=0x10, num=3, SRAM_LAT=2, shd_done 4 cycles after each v3, ras_ready=1 -> face_addr 0x10,0x11,0x12; 9 shd_valid beats; 3 ras triangles; finish.
REQ-031 num_faces=0 with start -> DONE, finish=1 within 2 cycles, no face_rd.
REQ-032 FIFO_DEPTH=4, num=8, ras_ready=0 -> exactly 4 face_rd, then stall; raising ras_ready resumes and all 8 delivered in order.
REQ-033 base=0xFFFFE, num=3 -> face_addr 0xFFFFE,0xFFFFF,0x00000.
REQ-034 shd_done pulse in IDLE -> err=1, ras_valid stays 0; srst_n low mid-frame -> all outputs 0 next cycle.
